// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: STAGES-deep destination scoreboard beside ID.
// Optional perf counters (stall_cycles, fwd_events) are enabled by HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int ZERO_REG   = 31,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_rm,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic              stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fwd_events
`endif
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } entry_t;

    // sb[0] is stage 1 (EX), sb[STAGES-1] is stage STAGES (WB).
    entry_t sb [STAGES];

    logic haz_a;
    logic haz_b;

    function automatic logic writes(input entry_t e, input logic [ADDR_W-1:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (e.rd != ZR);
    endfunction

    // Scanning oldest to youngest lets the youngest writer overwrite older results.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        haz_a     = 1'b0;
        haz_b     = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_rn_used && (id_rn != ZR) && writes(sb[k-1], id_rn)) begin
                haz_a     = sb[k-1].is_load && (k < LOAD_STAGE);
                fwd_a_sel = haz_a ? '0 : SEL_W'(k);
            end
            if (id_rm_used && (id_rm != ZR) && writes(sb[k-1], id_rm)) begin
                haz_b     = sb[k-1].is_load && (k < LOAD_STAGE);
                fwd_b_sel = haz_b ? '0 : SEL_W'(k);
            end
        end
    end

    assign stall = id_valid && !flush && (haz_a || haz_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                sb[k] <= sb[k-1];
            end
            if (id_valid && !stall && !flush) begin
                sb[0] <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
            end else begin
                sb[0] <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (((fwd_a_sel != '0) || (fwd_b_sel != '0)) && (fwd_events != 32'hFFFF_FFFF)) begin
                fwd_events <= fwd_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table with expected-result queue,
// plus a hand-written reset-during-stall sequence.
module tb_hazard_scoreboard;

    localparam int ADDR_W     = 5;
    localparam int STAGES     = 3;
    localparam int LOAD_STAGE = 2;
    localparam int ZERO_REG   = 31;
    localparam int SEL_W      = $clog2(STAGES + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rn;
    logic [ADDR_W-1:0] id_rm;
    logic              id_rn_used;
    logic              id_rm_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              flush;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic              stall;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       fwd_events;
`endif

    hazard_scoreboard #(
        .ADDR_W(ADDR_W), .STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic [ADDR_W-1:0] rn;
        logic              rn_used;
        logic [ADDR_W-1:0] rm;
        logic              rm_used;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              is_load;
        logic              fl;
        logic [SEL_W-1:0]  exp_a;
        logic [SEL_W-1:0]  exp_b;
        logic              exp_stall;
    } vec_t;

    vec_t vecs[$];
    logic [2*SEL_W:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_stall_cnt = 0;
    int exp_fwd_cnt = 0;

    function automatic vec_t mk(logic v, logic [ADDR_W-1:0] rn, logic ru, logic [ADDR_W-1:0] rm,
                                logic mu, logic [ADDR_W-1:0] rd, logic rw, logic ld, logic fl,
                                logic [SEL_W-1:0] ea, logic [SEL_W-1:0] eb, logic es);
        vec_t t;
        t.valid = v; t.rn = rn; t.rn_used = ru; t.rm = rm; t.rm_used = mu;
        t.rd = rd; t.regwrite = rw; t.is_load = ld; t.fl = fl;
        t.exp_a = ea; t.exp_b = eb; t.exp_stall = es;
        return t;
    endfunction

    task automatic check1(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_raw(input logic v, input logic [ADDR_W-1:0] rn, input logic ru,
                             input logic [ADDR_W-1:0] rm, input logic mu,
                             input logic [ADDR_W-1:0] rd, input logic rw, input logic ld,
                             input logic fl);
        id_valid = v; id_rn = rn; id_rn_used = ru; id_rm = rm; id_rm_used = mu;
        id_rd = rd; id_regwrite = rw; id_is_load = ld; flush = fl;
    endtask

    task automatic drive_vec(input vec_t t);
        drive_raw(t.valid, t.rn, t.rn_used, t.rm, t.rm_used, t.rd, t.regwrite, t.is_load, t.fl);
        exp_q.push_back({t.exp_a, t.exp_b, t.exp_stall});
        if (t.exp_stall) exp_stall_cnt++;
        if ((t.exp_a != 0) || (t.exp_b != 0)) exp_fwd_cnt++;
    endtask

    // Scoreboard: pop and compare once outputs have settled.
    task automatic sample(input int idx);
        logic [2*SEL_W:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty[%0d]: got 0 entries, expected 1", idx);
        end else begin
            e = exp_q.pop_front();
            check1("fwd_a_sel", idx, 32'(fwd_a_sel), 32'(e[2*SEL_W:SEL_W+1]));
            check1("fwd_b_sel", idx, 32'(fwd_b_sel), 32'(e[SEL_W:1]));
            check1("stall", idx, 32'(stall), 32'(e[0]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid rn ru rm mu rd rw ld fl | a b stall
        vecs.push_back(mk(1,  2,1,  3,1,  1,1,0,0, 0,0,0)); // ADDI X1, empty scoreboard
        vecs.push_back(mk(1,  1,1,  1,1,  2,1,0,0, 1,1,0)); // ADD X2,X1,X1
        vecs.push_back(mk(1,  1,1,  9,1,  8,1,0,0, 2,0,0)); // X1 at stage 2
        vecs.push_back(mk(1,  1,1,  2,1, 10,1,0,0, 3,2,0)); // X1 at 3, X2 at 2
        vecs.push_back(mk(1,  1,1, 10,1,  1,0,0,0, 0,1,0)); // X1 retired, non-writer enters
        vecs.push_back(mk(1, 10,1,  0,0,  3,1,1,0, 2,0,0)); // LDUR X3
        vecs.push_back(mk(1,  3,1,  5,1,  4,1,0,0, 0,0,1)); // load-use stall
        vecs.push_back(mk(1,  3,1,  5,1,  4,1,0,0, 2,0,0)); // held consumer forwards
        vecs.push_back(mk(1,  3,1,  4,1, 11,0,0,0, 3,1,0)); // load at 3, ALU at 1
        vecs.push_back(mk(1,  4,1,  0,0, 31,1,0,0, 2,0,0)); // ADDI X31
        vecs.push_back(mk(1, 31,1, 31,1,  6,1,0,0, 0,0,0)); // zero register never forwards
        vecs.push_back(mk(1,  6,1,  6,0, 12,1,0,0, 1,0,0)); // unused rm ignored
        vecs.push_back(mk(1, 12,1,  6,1,  7,1,0,0, 1,2,0)); // ADDI X7
        vecs.push_back(mk(1,  7,1,  0,0,  7,1,0,0, 1,0,0)); // ADDI X7 again
        vecs.push_back(mk(1,  7,1, 12,1,  7,1,1,0, 1,3,0)); // youngest X7 wins; LDUR X7
        vecs.push_back(mk(1,  7,1,  0,0, 13,1,0,0, 0,0,1)); // load X7 over ALU X7 stalls
        vecs.push_back(mk(1,  7,1,  0,0, 13,1,0,0, 2,0,0)); // load now at stage 2
        vecs.push_back(mk(1,  7,1,  0,0, 14,1,1,0, 3,0,0)); // LDUR X14
        vecs.push_back(mk(1, 14,1, 13,1, 15,1,0,1, 0,2,0)); // flush beats stall
        vecs.push_back(mk(1, 14,1, 13,1, 15,1,0,0, 2,3,0)); // shifted scoreboard only
        vecs.push_back(mk(1,  0,0,  0,0, 16,1,1,0, 0,0,0)); // LDUR X16
        vecs.push_back(mk(0, 16,1,  0,0,  0,0,0,0, 0,0,0)); // invalid ID never stalls
        vecs.push_back(mk(1, 16,1, 15,1, 17,1,0,1, 2,3,0)); // flushed ALU X17
        vecs.push_back(mk(1, 17,1, 16,1,  0,0,0,0, 0,3,0)); // X17 never entered

        drive_raw(1, 1, 1, 1, 1, 1, 1, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check1("reset_fwd_a", 0, 32'(fwd_a_sel), 0);
        check1("reset_fwd_b", 0, 32'(fwd_b_sel), 0);
        check1("reset_stall", 0, 32'(stall), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_vec(vecs[i]);
            sample(i);
        end

`ifdef HAZARD_PERF_EN
        check1("stall_cycles", 0, stall_cycles, 32'(exp_stall_cnt));
        check1("fwd_events", 0, fwd_events, 32'(exp_fwd_cnt));
`endif

        // Reset asserted while a load-use stall is active.
        drive_raw(1, 0, 0, 0, 0, 21, 1, 0, 0);     // ADDI X21
        @(posedge clk);
        #1;
        drive_raw(1, 0, 0, 0, 0, 20, 1, 1, 0);     // LDUR X20
        @(posedge clk);
        #1;
        drive_raw(1, 20, 1, 21, 1, 22, 1, 0, 0);   // consumer of X20, X21
        @(negedge clk);
        check1("pre_reset_stall", 1, 32'(stall), 1);
        check1("pre_reset_fwd_b", 1, 32'(fwd_b_sel), 2);
        #2 reset = 1'b0;
        #1;
        check1("mid_reset_stall", 1, 32'(stall), 0);
        check1("mid_reset_fwd_a", 1, 32'(fwd_a_sel), 0);
        check1("mid_reset_fwd_b", 1, 32'(fwd_b_sel), 0);
`ifdef HAZARD_PERF_EN
        check1("reset_stall_cycles", 1, stall_cycles, 0);
        check1("reset_fwd_events", 1, fwd_events, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check1("post_reset_stall", 2, 32'(stall), 0);
        check1("post_reset_fwd_a", 2, 32'(fwd_a_sel), 0);
        check1("post_reset_fwd_b", 2, 32'(fwd_b_sel), 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined core, placed beside the ID stage. It tracks destination registers of in-flight instructions in a STAGES-deep shift-register scoreboard (stage 1 = EX … stage STAGES = WB). From that state it produces, per source operand, a forwarding select and a load-use stall, with bubble insertion and ID-stage flush. It supersedes the fixed two-stage combinational forwarding unit: depth and load latency are generic, and it adds stalling and flushing.

## Interface
- ADDR_W, 5, register-address width
- STAGES, 3, number of tracked stages after ID (≥2)
- LOAD_STAGE, 2, first stage at which load data is forwardable (1 ≤ LOAD_STAGE ≤ STAGES)
- ZERO_REG, 31, hard-wired zero register index
- SEL_W, $clog2(STAGES+1), derived; forwarding-select width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn, id_rm  in  ADDR_W  source register addresses
- id_rn_used, id_rm_used  in  1  source actually read
- id_rd  in  ADDR_W  destination address
- id_regwrite  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is LDUR
- flush  in  1  kill ID instruction this cycle
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = regfile, k = stage k result
- stall  out  1  hold PC and IF/ID; bubble into stage 1

## Operation
- Scoreboard entry per stage k: {valid, rd, regwrite, is_load}. An entry "writes r" iff valid & regwrite & rd==r & rd!=ZERO_REG.
- Every rising edge: entry k+1 ← entry k for k=1..STAGES-1. Entry STAGES is discarded.
- Entry 1 ← ID fields when id_valid & !stall & !flush; otherwise entry 1 ← bubble (valid=0).
- Forward select for a source r (used, r!=ZERO_REG): youngest (lowest k) entry writing r.
  - ALU entry: sel = k.
  - Load entry with k ≥ LOAD_STAGE: sel = k.
  - Load entry with k < LOAD_STAGE: hazard; sel = 0.
- Unused source or r==ZERO_REG: sel = 0, never hazards. No writing entry: sel = 0.
- stall = id_valid & !flush & (hazard on rn | hazard on rm).
- Priority: flush > stall. When flush=1, stall=0 and a bubble enters stage 1.
- Only the youngest match is considered. An older ALU producer never hides a younger load hazard.

## Timing
- fwd_*_sel and stall are combinational from the ID inputs and registered scoreboard state, valid in the same cycle.
- Load-use stall length = LOAD_STAGE − k for producer at stage k. With defaults, LDUR immediately followed by a consumer stalls exactly 1 cycle, then fwd sel = 2.
- Scoreboard state changes only on the clock edge. Each stall cycle inserts exactly one bubble.
- Reset asserted (reset=0) asynchronously clears all valid bits. stall=0, both sels=0 while in reset and on the first cycle after release. Counters (below) clear to 0.
- Reset mid-stall: stall drops immediately and in-flight producers are forgotten.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cycles [31:0] and fwd_events [31:0].
  - stall_cycles increments on every cycle with stall=1.
  - fwd_events increments on every cycle with fwd_a_sel!=0 or fwd_b_sel!=0, +1 per cycle, not per operand.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- HAZARD_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- ALU chain: ADDI X1 then ADD X2,X1,X1 next cycle → fwd_a_sel=fwd_b_sel=1, stall=0. One cycle later with consumer of X1 → sel=2; two cycles later → sel=3.
- Load-use: LDUR X3 then ADD X4,X3,X5 → stall=1 for exactly 1 cycle, stage 1 bubble. Next cycle fwd_a_sel=2, fwd_b_sel=0.
- Zero register: ADDI X31 then ADD X6,X31,X31 → sels 0, stall 0. A consumer with id_rm_used=0 matching a producer → fwd_b_sel=0.
- Youngest wins: ADDI X7 (stage 2) and ADDI X7 (stage 1), consumer of X7 → sel=1. Load X7 in stage 1 over ALU X7 in stage 2 → stall=1.
- Flush vs stall: load-use condition with flush=1 → stall=0, entry 1 bubble. Next cycle sels reflect the shifted scoreboard only.
- Reset mid-operation: with stall=1, drive reset=0 asynchronously → stall and sels drop to 0 immediately. With HAZARD_PERF_EN, stall_cycles=0.
